// File: rtl/adder_pipe_if.sv
// adder_pipe_if: operand/result handshake bundle for adder_pipe.
// ovf exists only when ADDER_PIPE_OVF_EN is defined.
interface adder_pipe_if #(
  parameter int WIDTH = 8
);
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] add;
  logic [WIDTH-1:0] aug;
  logic             preC;
  logic             sub;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] sum;
  logic             proC;
`ifdef ADDER_PIPE_OVF_EN
  logic             ovf;
`endif

  modport master (
    output inValid, add, aug, preC, sub,
    output outReady,
`ifdef ADDER_PIPE_OVF_EN
    input  ovf,
`endif
    input  inReady, outValid, sum, proC
  );

  modport slave (
    input  inValid, add, aug, preC, sub,
    input  outReady,
`ifdef ADDER_PIPE_OVF_EN
    output ovf,
`endif
    output inReady, outValid, sum, proC
  );
endinterface

// File: rtl/adder_pipe.sv
// adder_pipe: chunked pipelined add/sub, one CHUNK per stage, global stall.
// Optional signed-overflow output enabled by ADDER_PIPE_OVF_EN.
module adder_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  adder_pipe_if.slave bus
);
  localparam int C = WIDTH / STAGES;

  logic adv;

  for (genvar k = 0; k < STAGES; k++) begin : g
    localparam int RW = WIDTH - k * C;
    localparam int SW = (k + 1) * C;

    logic [RW-1:0] ai;
    logic [RW-1:0] bi;
    logic          ci;
    logic          vi;
    logic [C:0]    t;
    logic [SW-1:0] sn;
    logic [SW-1:0] s;
    logic          v;
    logic          c;

    if (k == 0) begin : src
      assign ai = bus.add;
      assign bi = bus.sub ? ~bus.aug : bus.aug;
      assign ci = bus.sub | bus.preC;
      assign vi = bus.inValid;
      assign sn = t[C-1:0];
    end else begin : src
      assign ai = g[k-1].hi.a;
      assign bi = g[k-1].hi.b;
      assign ci = g[k-1].c;
      assign vi = g[k-1].v;
      assign sn = {t[C-1:0], g[k-1].s};
    end

    assign t = {1'b0, ai[C-1:0]}
             + {1'b0, bi[C-1:0]}
             + {{C{1'b0}}, ci};

    // data holds across bubbles so sum only moves on a real load
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v <= 1'b0;
        c <= 1'b0;
        s <= '0;
      end else if (adv) begin
        v <= vi;
        if (vi) begin
          c <= t[C];
          s <= sn;
        end
      end
    end

    if (k < STAGES - 1) begin : hi
      logic [RW-C-1:0] a;
      logic [RW-C-1:0] b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a <= '0;
          b <= '0;
        end else if (adv && vi) begin
          a <= ai[RW-1:C];
          b <= bi[RW-1:C];
        end
      end
    end

`ifdef ADDER_PIPE_OVF_EN
    if (k == STAGES - 1) begin : of
      logic o;

      // carry into MSB is recovered from the MSB sum bit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          o <= 1'b0;
        end else if (adv && vi) begin
          o <= ai[RW-1] ^ bi[RW-1]
             ^ t[C-1] ^ t[C];
        end
      end
    end
`endif
  end

  assign adv          = !g[STAGES-1].v || bus.outReady;
  assign bus.inReady  = adv;
  assign bus.outValid = g[STAGES-1].v;
  assign bus.sum      = g[STAGES-1].s;
  assign bus.proC     = g[STAGES-1].c;
`ifdef ADDER_PIPE_OVF_EN
  assign bus.ovf      = g[STAGES-1].of.o;
`endif
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed vectors for adder_pipe, WIDTH=8 STAGES=2.
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_adder_pipe;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  adder_pipe_if #(.WIDTH(8)) bif ();

  adder_pipe #(
    .WIDTH (8),
    .STAGES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [8:0] obs,
                     input logic [8:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic       c,
                       input logic       s);
    bif.inValid = 1'b1;
    bif.add     = a;
    bif.aug     = b;
    bif.preC    = c;
    bif.sub     = s;
  endtask

  task automatic res(input string tag,
                     input logic [7:0] s,
                     input logic       c);
    chk({tag, "_v"}, {8'h0, bif.outValid}, 9'h1);
    chk({tag, "_s"}, {1'b0, bif.sum}, {1'b0, s});
    chk({tag, "_c"}, {8'h0, bif.proC}, {8'h0, c});
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bif.inValid  = 1'b0;
    bif.add      = '0;
    bif.aug      = '0;
    bif.preC     = 1'b0;
    bif.sub      = 1'b0;
    bif.outReady = 1'b1;
    step();
    step();
    chk("rst_v", {8'h0, bif.outValid}, 9'h0);
    chk("rst_s", {1'b0, bif.sum}, 9'h0);
    chk("rst_c", {8'h0, bif.proC}, 9'h0);
    chk("rst_rdy", {8'h0, bif.inReady}, 9'h1);
    rst_n = 1'b1;
    step();

    issue(8'h0F, 8'h01, 1'b0, 1'b0);
    step();
    chk("lat1", {8'h0, bif.outValid}, 9'h0);
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    step();
    res("t1", 8'h10, 1'b0);
    issue(8'hFF, 8'hFF, 1'b1, 1'b0);
    step();
    res("wrap", 8'h00, 1'b1);
    issue(8'h05, 8'h07, 1'b1, 1'b1);
    step();
    res("ffff", 8'hFF, 1'b1);
    issue(8'h07, 8'h05, 1'b0, 1'b1);
    step();
    res("sub1", 8'hFE, 1'b0);
    bif.inValid = 1'b0;
    step();
    res("sub2", 8'h02, 1'b1);
    step();
    chk("bub", {8'h0, bif.outValid}, 9'h0);

    issue(8'h01, 8'h01, 1'b0, 1'b0);
    step();
    issue(8'h02, 8'h02, 1'b0, 1'b0);
    step();
    res("bp0", 8'h02, 1'b0);
    issue(8'h03, 8'h03, 1'b0, 1'b0);
    bif.outReady = 1'b0;
    #1;
    chk("bp_rdy0", {8'h0, bif.inReady}, 9'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      res("bp_hold", 8'h02, 1'b0);
      chk("bp_rdy", {8'h0, bif.inReady}, 9'h0);
    end
    bif.outReady = 1'b1;
    #1;
    chk("bp_rdy1", {8'h0, bif.inReady}, 9'h1);
    step();
    res("bp4", 8'h04, 1'b0);
    bif.inValid = 1'b0;
    step();
    res("bp6", 8'h06, 1'b0);
    step();
    chk("bp_end", {8'h0, bif.outValid}, 9'h0);

    issue(8'hF0, 8'h20, 1'b0, 1'b0);
    step();
    issue(8'h33, 8'h44, 1'b0, 1'b0);
    bif.outReady = 1'b0;
    step();
    bif.inValid = 1'b0;
    res("pre_rst", 8'h10, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_v", {8'h0, bif.outValid}, 9'h0);
    chk("arst_s", {1'b0, bif.sum}, 9'h0);
    chk("arst_c", {8'h0, bif.proC}, 9'h0);
    step();
    rst_n = 1'b1;
    bif.outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stale", {8'h0, bif.outValid}, 9'h0);
    end

`ifdef ADDER_PIPE_OVF_EN
    issue(8'h7F, 8'h01, 1'b0, 1'b0);
    step();
    issue(8'h80, 8'h01, 1'b0, 1'b1);
    step();
    res("ovf1", 8'h80, 1'b0);
    chk("ovf1_o", {8'h0, bif.ovf}, 9'h1);
    issue(8'h10, 8'h20, 1'b0, 1'b0);
    step();
    res("ovf2", 8'h7F, 1'b1);
    chk("ovf2_o", {8'h0, bif.ovf}, 9'h1);
    bif.inValid = 1'b0;
    step();
    res("ovf3", 8'h30, 1'b0);
    chk("ovf3_o", {8'h0, bif.ovf}, 9'h0);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
